// File: rtl/comm_pkg.sv
// Shared definitions for both ends of the serial command link:
// the state encodings and the default bit period.
package comm_pkg;

    localparam int BAUD_DIV_DEFAULT = 2604;

    typedef enum logic {
        WAIT_HIGH = 1'b0,
        WAIT_LOW  = 1'b1
    } asm_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Number of bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: synchronizes RX, finds the start edge, samples each bit
// at mid-period, and reports a good byte or a framing error as one-cycle pulses.
module uart_rx
    import comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       start,
    output logic       byte_rdy,
    output logic       frm_err
);

    localparam int CW = cnt_width(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    logic [1:0]      sync_vld;
    logic            armed;
    logic            fall_edge;
    rx_state_t       state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            sample_done;
    logic            stop_bit;

    // The presets hide the real line level for two clocks after reset, so
    // start detection only arms once a genuine high has come through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && rx_sync)
                armed <= 1'b1;
        end
    end

    assign fall_edge = armed & rx_prev & ~rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            sample_done <= 1'b0;
            stop_bit    <= 1'b0;
            start       <= 1'b0;
        end else begin
            start       <= 1'b0;
            sample_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall_edge) begin
                        state    <= START;
                        baud_cnt <= '0;
                        start    <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= rx_sync ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt    <= '0;
                        state       <= IDLE;
                        sample_done <= 1'b1;
                        stop_bit    <= rx_sync;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result pulses lag the stop sample by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_rdy <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            byte_rdy <= sample_done & stop_bit;
            frm_err  <= sample_done & ~stop_bit;
        end
    end

    assign rx_data = shreg;

endmodule

// File: rtl/cmd_rcv.sv
// Receive-side command interface: pairs UART bytes (high first) into 16-bit
// commands, with an inter-byte timeout that resynchronizes after a lost frame.
module cmd_rcv
    import comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int TIMEOUT  = 65536
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        rx_err
);

    localparam int TW = cnt_width(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [7:0]    rx_data;
    logic          rx_start;
    logic          byte_rdy;
    logic          frm_err;
    asm_state_t    state;
    logic [7:0]    high_byte;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_frozen;

    uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (RX),
        .rx_data  (rx_data),
        .start    (rx_start),
        .byte_rdy (byte_rdy),
        .frm_err  (frm_err)
    );

    // Later assignments to cmd_rdy override the clear, so a completing
    // command wins over a simultaneous acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_HIGH;
            high_byte  <= 8'h00;
            tmo_cnt    <= '0;
            tmo_frozen <= 1'b0;
            cmd        <= 16'h0000;
            cmd_rdy    <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            rx_err <= 1'b0;
            if (clr_cmd_rdy)
                cmd_rdy <= 1'b0;
            case (state)
                WAIT_HIGH: begin
                    if (rx_start)
                        cmd_rdy <= 1'b0;
                    if (frm_err) begin
                        rx_err <= 1'b1;
                    end else if (byte_rdy) begin
                        high_byte  <= rx_data;
                        tmo_cnt    <= '0;
                        tmo_frozen <= 1'b0;
                        state      <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (frm_err) begin
                        rx_err    <= 1'b1;
                        high_byte <= 8'h00;
                        state     <= WAIT_HIGH;
                    end else if (byte_rdy) begin
                        cmd     <= {high_byte, rx_data};
                        cmd_rdy <= 1'b1;
                        state   <= WAIT_HIGH;
                    end else if (rx_start) begin
                        tmo_frozen <= 1'b1;
                    end else if (!tmo_frozen) begin
                        if (tmo_cnt == TMO_LAST) begin
                            rx_err    <= 1'b1;
                            high_byte <= 8'h00;
                            state     <= WAIT_HIGH;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                end
                default: state <= WAIT_HIGH;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_rcv.sv
// Scoreboard bench for cmd_rcv: expected commands are queued as frames are
// sent and popped each time cmd_rdy rises.
module tb_cmd_rcv;

    localparam int BAUD_DIV = 16;
    localparam int TIMEOUT  = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        rx_err;

    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    int          err_count = 0;
    int          err_cycle = 0;
    logic [15:0] exp_q[$];

    cmd_rcv #(
        .BAUD_DIV (BAUD_DIV),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .rx_err      (rx_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b);
        RX = b;
        repeat (BAUD_DIV) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++)
            sendBit(data[i]);
        sendBit(stop);
    endtask

    // Output monitor: scoreboard pops, set/clear timing of cmd_rdy, rx_err pulses.
    initial begin : monitor
        logic        prev_rdy;
        logic        prev_clr;
        logic        prev_br;
        logic        prev_err;
        int          err_run;
        logic [15:0] exp_val;
        prev_rdy = 1'b0;
        prev_clr = 1'b0;
        prev_br  = 1'b0;
        prev_err = 1'b0;
        err_run  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rdy = 1'b0;
                prev_clr = 1'b0;
                prev_br  = 1'b0;
                prev_err = 1'b0;
                err_run  = 0;
            end else begin
                if (cmd_rdy && !prev_rdy) begin
                    checkOutput("rdy_after_byte_rdy", 32'(prev_br), 32'd1);
                    checkOutput("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_val = exp_q.pop_front();
                        checkOutput("cmd", 32'(cmd), 32'(exp_val));
                    end
                end
                if (prev_rdy && prev_clr)
                    checkOutput("clr_rdy", 32'(cmd_rdy), 32'd0);
                if (rx_err) begin
                    err_run++;
                end else if (err_run != 0) begin
                    checkOutput("rx_err_width", 32'(err_run), 32'd1);
                    err_run = 0;
                end
                if (rx_err && !prev_err) begin
                    err_count++;
                    err_cycle = cycle;
                end
                prev_rdy = cmd_rdy;
                prev_clr = clr_cmd_rdy;
                prev_br  = dut.u_rx.byte_rdy;
                prev_err = rx_err;
            end
        end
    end

    initial begin
        int t0;
        int e0;
        logic [7:0] dead_lo;

        repeat (4) @(negedge clk);
        checkOutput("rst_cmd", 32'(cmd), 32'h0000);
        checkOutput("rst_rdy", 32'(cmd_rdy), 32'd0);
        checkOutput("rst_err", 32'(rx_err), 32'd0);
        rst_n = 1'b1;
        waitCycles(4);

        applyStimulus(8'hA5, 1'b1);
        exp_q.push_back(16'hA55A);
        applyStimulus(8'h5A, 1'b1);
        waitCycles(4);
        checkOutput("a55a_cmd", 32'(cmd), 32'hA55A);
        checkOutput("a55a_rdy", 32'(cmd_rdy), 32'd1);
        checkOutput("a55a_no_err", 32'(err_count), 32'd0);

        // Back-to-back frames, no idle gap, no acknowledge.
        applyStimulus(8'h12, 1'b1);
        exp_q.push_back(16'h1234);
        applyStimulus(8'h34, 1'b1);
        checkOutput("b2b_rdy_set", 32'(cmd_rdy), 32'd1);
        applyStimulus(8'hBE, 1'b1);
        checkOutput("b2b_rdy_drop", 32'(cmd_rdy), 32'd0);
        exp_q.push_back(16'hBEEF);
        applyStimulus(8'hEF, 1'b1);
        waitCycles(4);
        checkOutput("b2b_cmd", 32'(cmd), 32'hBEEF);
        checkOutput("b2b_rdy", 32'(cmd_rdy), 32'd1);

        // Inter-byte timeout drops the lone high byte.
        applyStimulus(8'h12, 1'b1);
        t0 = cycle;
        e0 = err_count;
        waitCycles(500);
        checkOutput("tmo_err_count", 32'(err_count - e0), 32'd1);
        checkOutput("tmo_window", 32'((err_cycle - t0 >= 380) && (err_cycle - t0 <= 420)), 32'd1);
        applyStimulus(8'h34, 1'b1);
        exp_q.push_back(16'h3456);
        applyStimulus(8'h56, 1'b1);
        waitCycles(4);
        checkOutput("tmo_cmd", 32'(cmd), 32'h3456);

        // Framing error on the high byte.
        e0 = err_count;
        applyStimulus(8'h77, 1'b0);
        RX = 1'b1;
        waitCycles(2 * BAUD_DIV);
        checkOutput("frm_err_count", 32'(err_count - e0), 32'd1);
        checkOutput("frm_no_rdy", 32'(cmd_rdy), 32'd0);
        applyStimulus(8'hCA, 1'b1);
        exp_q.push_back(16'hCAFE);
        applyStimulus(8'hFE, 1'b1);
        waitCycles(4);
        checkOutput("frm_cmd", 32'(cmd), 32'hCAFE);

        // Acknowledge held through completion: set wins, then clears.
        applyStimulus(8'h0F, 1'b1);
        clr_cmd_rdy = 1'b1;
        exp_q.push_back(16'h0F0F);
        applyStimulus(8'h0F, 1'b1);
        waitCycles(4);
        clr_cmd_rdy = 1'b0;
        checkOutput("clr_cmd_kept", 32'(cmd), 32'h0F0F);
        checkOutput("clr_rdy_low", 32'(cmd_rdy), 32'd0);

        // Reset midway through the low byte; released while RX is low.
        applyStimulus(8'hDE, 1'b1);
        dead_lo = 8'hAD;
        sendBit(1'b0);
        for (int i = 0; i < 4; i++)
            sendBit(dead_lo[i]);
        RX = dead_lo[4];
        waitCycles(BAUD_DIV / 2);
        rst_n = 1'b0;
        waitCycles(2);
        checkOutput("midrst_cmd", 32'(cmd), 32'h0000);
        checkOutput("midrst_rdy", 32'(cmd_rdy), 32'd0);
        checkOutput("midrst_err", 32'(rx_err), 32'd0);
        waitCycles(BAUD_DIV / 2 - 2);
        sendBit(dead_lo[5]);
        RX = dead_lo[6];
        waitCycles(BAUD_DIV / 2);
        rst_n = 1'b1;
        waitCycles(BAUD_DIV / 2);
        sendBit(dead_lo[7]);
        sendBit(1'b1);
        waitCycles(2 * BAUD_DIV);
        applyStimulus(8'h42, 1'b1);
        exp_q.push_back(16'h4242);
        applyStimulus(8'h42, 1'b1);
        waitCycles(4);
        checkOutput("post_rst_cmd", 32'(cmd), 32'h4242);
        checkOutput("post_rst_rdy", 32'(cmd_rdy), 32'd1);

        checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("total_err", 32'(err_count), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmd_rcv.md
# cmd_rcv

Receive-side command interface: deserializes a UART byte stream on `RX` and assembles each pair of bytes, high byte first, into one 16-bit command. The command is presented on `cmd` with a sticky `cmd_rdy` flag. It sits at the slave end of the serial command link, facing the block that transmits 16-bit commands as two 8N1 UART frames. An inter-byte timeout resynchronizes the byte pairing after a lost frame.

## Interface
- `BAUD_DIV`, 2604: clocks per bit (50 MHz / 19200 baud); must be ≥ 8.
- `TIMEOUT`, 65536: clocks allowed between the high-byte stop sample and the low-byte start edge.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `RX` in 1: serial input, idle high, asynchronous to `clk`.
- `clr_cmd_rdy` in 1: consumer acknowledge; clears `cmd_rdy`.
- `cmd` out 16: last complete command, `{high_byte, low_byte}`.
- `cmd_rdy` out 1: a complete command is held in `cmd`.
- `rx_err` out 1: one-cycle pulse on a framing error or an inter-byte timeout.

## Operation
- `RX` is double-flopped; both flops preset to 1 on reset.
- Byte receiver:
  - A falling edge on synchronized `RX` while idle starts a frame.
  - Start bit sampled at `BAUD_DIV/2`; if it reads 1, the frame is a glitch, discarded silently, and the receiver returns to idle.
  - 8 data bits sampled every `BAUD_DIV` after the start sample, LSB first, then the stop bit.
  - Stop = 1: one-cycle `byte_rdy` pulse with `rx_data`.
  - Stop = 0: framing error.
- Assembly FSM states:
  - WAIT_HIGH: on `byte_rdy`, latch `high_byte`, clear the timeout counter, go to WAIT_LOW.
  - WAIT_LOW: counter increments each clock.
    - On `byte_rdy`: load `cmd <= {high_byte, rx_data}`, set `cmd_rdy`, go to WAIT_HIGH.
    - If the counter reaches `TIMEOUT` before a start edge: pulse `rx_err`, drop `high_byte`, go to WAIT_HIGH.
    - The counter freezes once a start edge is seen.
- A framing error in either state pulses `rx_err`, discards the byte, and forces WAIT_HIGH.
- `cmd_rdy` clear conditions:
  - cleared by `clr_cmd_rdy`;
  - cleared by the start edge of a new high byte.
- If `cmd_rdy` is set and `clr_cmd_rdy` is asserted in the same cycle, set wins.
- `cmd` holds its value until the next completed command; it is never cleared by `clr_cmd_rdy`.

## Timing
- Reset values: `cmd` = 0x0000, `cmd_rdy` = 0, `rx_err` = 0, FSM = WAIT_HIGH, receiver idle.
- `cmd` and `cmd_rdy` update on the same edge: one clock after the `byte_rdy` pulse.
- From the low-byte stop-bit sample to `cmd_rdy` high: 2 clocks.
- Synchronizer latency: 2 clocks from the `RX` edge to start detection.
- `rx_err` pulse width is exactly one clock.
- Back-to-back frames with zero idle stop-to-start gap must be received.
- Reset asserted mid-frame: everything returns to reset values immediately. A partial frame in progress when reset releases is lost. The receiver waits for `RX` high before arming start detection, so it never starts on a mid-byte low.

## Structure
- Shared package `comm_pkg` holds:
  - the assembly state typedef (WAIT_HIGH, WAIT_LOW);
  - the receiver state typedef (IDLE, START, DATA, STOP);
  - the default `BAUD_DIV` constant, shared with the transmit side.
- Sub-module `uart_rx`: synchronizer, baud counter, bit counter, shift register. Outputs `rx_data[7:0]`, one-cycle `byte_rdy`, and one-cycle `frm_err`.
- `cmd_rcv` contains `uart_rx`, the assembly FSM, the timeout counter, the command register and the flag logic.

## Test plan
Simulate with `BAUD_DIV` = 16 and `TIMEOUT` = 400.
- Command 0xA55A sent as frames 0xA5 then 0x5A → `cmd` = 0xA55A and `cmd_rdy` = 1 exactly 2 clocks after the 0x5A stop sample; `rx_err` never pulses.
- Commands 0x1234 and 0xBEEF sent back-to-back with no idle gap, no `clr_cmd_rdy` → `cmd_rdy` drops at the 0xBEEF start edge, then `cmd` = 0xBEEF with `cmd_rdy` = 1.
- 0x12 sent, then `RX` held idle for 500 clocks, then 0x34, 0x56 → one `rx_err` pulse about 400 clocks after the 0x12 stop sample; final `cmd` = 0x3456.
- High byte 0x77 sent with stop bit forced 0, then 0xCAFE → one `rx_err` pulse, no `cmd_rdy` for 0x77, `cmd` = 0xCAFE.
- `clr_cmd_rdy` held high through completion of 0x0F0F → `cmd_rdy` = 1 on the completion cycle (set wins), 0 on the next cycle.
- `rst_n` pulsed low midway through the low byte of 0xDEAD → outputs at reset values; following 0x4242 gives `cmd` = 0x4242.
